// File: rtl/mem_rr_scheduler.sv
// Round-robin owner scheduler for a single-port memory shared by N clients.
// The owner's commands are muxed onto the memory port; read data is routed back by client id.
module mem_rr_scheduler #(
    parameter int N        = 4,
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 32,
    parameter int RD_LAT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    cmd_valid,
    input  logic [N-1:0]    cmd_we,
    input  logic [N*AW-1:0] cmd_addr,
    input  logic [N*DW-1:0] cmd_wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    localparam logic [N-1:0] ONE_OH = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state_r, state_s;
    logic [IW-1:0] owner_r, owner_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [N-1:0]  gnt_s;

    logic [RD_LAT-1:0] pipe_vld_r;
    logic [IW-1:0]     pipe_id_r [RD_LAT];

    logic [N-1:0] owner_oh_s;
    logic         others_req_s;
    logic         quota_hit_s;
    logic         release_s;
    logic         pipe_empty_s;

    // First set request at or after p, wrapping N-1 -> 0.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic found;
        int   idx;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(p) + k) % N;
            if (!found && r[idx]) begin
                rr_pick = IW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // Release conditions: owner drops its request, or quota spent while someone else waits.
    always_comb begin
        owner_oh_s   = ONE_OH << owner_r;
        others_req_s = |(req & ~owner_oh_s);
        quota_hit_s  = (MAX_HOLD != 0) && (int'(hold_cnt_r) == MAX_HOLD - 1) && others_req_s;
        release_s    = (state_r == ST_OWN) && (!req[owner_r] || quota_hit_s);
        pipe_empty_s = ~|pipe_vld_r;
    end

    // Next-state logic for ownership FSM, pointer and hold counter.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_s    = ST_OWN;
                    owner_s    = rr_pick(req, ptr_r);
                    gnt_s      = ONE_OH << owner_s;
                    hold_cnt_s = {HW{1'b0}};
                end else begin
                    gnt_s = {N{1'b0}};
                end
            end
            ST_OWN: begin
                if (release_s) begin
                    state_s    = ST_REL;
                    gnt_s      = {N{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                    if (int'(owner_r) == N - 1) begin
                        ptr_s = {IW{1'b0}};
                    end else begin
                        ptr_s = owner_r + IW'(1);
                    end
                end else if ((MAX_HOLD != 0) && (int'(hold_cnt_r) < MAX_HOLD - 1)) begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            ST_REL: begin
                // Ownership only moves once every outstanding read has returned.
                if (pipe_empty_s && (|req)) begin
                    state_s = ST_OWN;
                    owner_s = rr_pick(req, ptr_r);
                    gnt_s   = ONE_OH << owner_s;
                end else if (pipe_empty_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = {N{1'b0}};
                end else begin
                    gnt_s = {N{1'b0}};
                end
            end
            default: begin
                state_s    = ST_IDLE;
                gnt_s      = {N{1'b0}};
                hold_cnt_s = {HW{1'b0}};
            end
        endcase
    end

    // FSM and grant registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= {IW{1'b0}};
            ptr_r      <= {IW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            gnt        <= {N{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt        <= gnt_s;
        end
    end

    // Memory port mux: only the owner's command reaches the memory, zeros otherwise.
    always_comb begin
        mem_en = (state_r == ST_OWN) && cmd_valid[owner_r];
        if (mem_en) begin
            mem_we    = cmd_we[owner_r];
            mem_addr  = cmd_addr[owner_r*AW +: AW];
            mem_wdata = cmd_wdata[owner_r*DW +: DW];
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    // Read-return pipe tracking {valid, client id} across the memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_id_r[i] <= {IW{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= mem_en && !mem_we;
            pipe_id_r[0]  <= owner_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_id_r[i]  <= pipe_id_r[i-1];
            end
        end
    end

    // Read data steering and status.
    always_comb begin
        if (pipe_vld_r[RD_LAT-1]) begin
            rvalid = ONE_OH << pipe_id_r[RD_LAT-1];
            rdata  = mem_rdata;
        end else begin
            rvalid = {N{1'b0}};
            rdata  = {DW{1'b0}};
        end
        busy = (state_r != ST_IDLE) || !pipe_empty_s;
    end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed bench for mem_rr_scheduler with a latency-2 memory model and a read-return scoreboard.
module tb_mem_rr_scheduler;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    cmd_valid;
    logic [N-1:0]    cmd_we;
    logic [N*AW-1:0] cmd_addr;
    logic [N*DW-1:0] cmd_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } rd_t;
    rd_t sb_q[$];

    mem_rr_scheduler #(.N(N), .AW(AW), .DW(DW), .MAX_HOLD(4), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_valid(cmd_valid), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: 256 words, initial content 0x1000+addr, read data two cycles after mem_en.
    logic [15:0] mem [256];
    logic [7:0]  d1_addr = 8'd0;
    logic [7:0]  d2_addr = 8'd0;
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
            init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        d1_addr <= mem_addr[7:0];
        d2_addr <= d1_addr;
    end
    assign mem_rdata = mem[d2_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard check of the read-return port, once per cycle.
    task automatic mon();
        rd_t e;
        if (rvalid != 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("spurious_rvalid", {28'd0, rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rvalid_id", {28'd0, rvalid}, {28'd0, 4'b0001 << e.id});
                chk("rdata", {16'd0, rdata}, {16'd0, e.data});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
        cmd_valid[c]          = 1'b1;
        cmd_we[c]             = we;
        cmd_addr[c*16 +: 16]  = a;
        cmd_wdata[c*16 +: 16] = d;
    endtask

    task automatic clr_cmd();
        cmd_valid = 4'b0000;
        cmd_we    = 4'b0000;
    endtask

    initial begin
        logic [3:0] exp_g;
        rst = 1'b1; req = 4'b0000; cmd_valid = 4'b0000; cmd_we = 4'b0000;
        cmd_addr = 64'd0; cmd_wdata = 64'd0;
        tick(); tick();
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_rvalid", {28'd0, rvalid}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Single request, non-owner commands ignored
        req = 4'b0010;
        tick();
        chk("t1_gnt", {28'd0, gnt}, 32'h2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        cmd(0, 1'b0, 16'h0011, 16'h0000);
        cmd(2, 1'b1, 16'h0022, 16'h2222);
        cmd(3, 1'b0, 16'h0033, 16'h0000);
        #1;
        chk("t1_nonowner_en", {31'd0, mem_en}, 32'd0);
        chk("t1_nonowner_addr", {16'd0, mem_addr}, 32'd0);
        clr_cmd(); req = 4'b0000;
        tick();
        chk("t1_release_gnt", {28'd0, gnt}, 32'd0);

        // Client 2 write then read-back (ptr now 2)
        req = 4'b0100;
        tick();
        chk("t2_gnt", {28'd0, gnt}, 32'h4);
        cmd(2, 1'b1, 16'h0040, 16'hBEEF);
        cmd(0, 1'b0, 16'h1234, 16'h5555);
        #1;
        chk("t2_wr_en", {31'd0, mem_en}, 32'd1);
        chk("t2_wr_we", {31'd0, mem_we}, 32'd1);
        chk("t2_wr_addr", {16'd0, mem_addr}, 32'h0040);
        chk("t2_wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        tick();
        clr_cmd();
        cmd(2, 1'b0, 16'h0040, 16'h0000);
        sb_q.push_back('{id: 2'd2, data: 16'hBEEF});
        #1;
        chk("t2_rd_en", {31'd0, mem_en}, 32'd1);
        chk("t2_rd_we", {31'd0, mem_we}, 32'd0);
        tick();
        clr_cmd(); req = 4'b0000;
        #1;
        chk("t2_idle_en", {31'd0, mem_en}, 32'd0);
        chk("t2_idle_wdata", {16'd0, mem_wdata}, 32'd0);
        tick();
        chk("t2_rel_gnt", {28'd0, gnt}, 32'd0);
        tick(); tick();
        chk("t2_busy_idle", {31'd0, busy}, 32'd0);

        // Round robin with quota 4 and one RELEASE cycle between owners
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int j = 0; j < 21; j++) begin
            tick();
            exp_g = ((j % 5) < 4) ? (4'b0001 << ((j / 5) % 4)) : 4'b0000;
            chk("t3_rr_gnt", {28'd0, gnt}, {28'd0, exp_g});
        end
        req = 4'b0000;
        tick(); tick(); tick();

        // Read drain before handover, RD_LAT=2
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0001;
        tick();
        chk("t4_gnt0", {28'd0, gnt}, 32'h1);
        cmd(0, 1'b0, 16'h0010, 16'h0000);
        req = 4'b0011;
        sb_q.push_back('{id: 2'd0, data: 16'h1010});
        tick();
        cmd(0, 1'b0, 16'h0011, 16'h0000);
        sb_q.push_back('{id: 2'd0, data: 16'h1011});
        tick();
        clr_cmd(); req = 4'b0010;
        #1;
        chk("t4_rv_first", {28'd0, rvalid}, 32'h1);
        chk("t4_rd_first", {16'd0, rdata}, 32'h1010);
        tick();
        chk("t4_rel1_gnt", {28'd0, gnt}, 32'd0);
        chk("t4_rv_second", {28'd0, rvalid}, 32'h1);
        chk("t4_rd_second", {16'd0, rdata}, 32'h1011);
        chk("t4_rel1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t4_rel2_gnt", {28'd0, gnt}, 32'd0);
        chk("t4_rel2_rvalid", {28'd0, rvalid}, 32'd0);
        tick();
        chk("t4_gnt1", {28'd0, gnt}, 32'h2);

        // Lone requester keeps grant past quota, counter saturates
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_hold_gnt", {28'd0, gnt}, 32'h2);
        end
        chk("t5_hold_sat", 32'(dut.hold_cnt_r), 32'd3);

        // Reset with a read in flight: no rvalid may follow, ptr back to 0
        cmd(1, 1'b0, 16'h0020, 16'h0000);
        tick();
        clr_cmd(); rst = 1'b1;
        tick();
        chk("t6_rst_gnt", {28'd0, gnt}, 32'd0);
        chk("t6_rst_rvalid", {28'd0, rvalid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; req = 4'b0001;
        tick();
        chk("t6_gnt_ptr0", {28'd0, gnt}, 32'h1);
        req = 4'b0000;
        tick(); tick(); tick(); tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
